ex_div_seq: RTL and testbench

Iterative 32-bit integer divider for the ex stage. It covers DIV/DIVU/REM/REMU and is built around the stage's existing combinational adder. The block sits directly upstream of the adder and drives its opr0/opr1/minus inputs. It consumes the adder's 33-bit result in the same cycle, with one adder operation per clock. Results go to the ex-stage result mux through a start/busy/done handshake.

---
 rtl/ex_div_seq_if.sv | 28 ++
 rtl/ex_div_seq.sv | 166 ++++++++++++++++
 tb/tb_ex_div_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_seq_if.sv
// Request/result bundle between the ex-stage issue logic and the iterative divider.
// Latency: none, wiring only.
// Backpressure: the requester must hold off while busy is high, because start is ignored then.
interface ex_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // The requester drives operands and flush, and observes status and results.
    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder
    );

    // The divider samples operands and flush, and drives status and results.
    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/ex_div_seq.sv
// Iterative restoring 32-bit divider (DIV/DIVU/REM/REMU) that borrows the ex-stage adder.
// Latency: 36 busy cycles; done pulses for one cycle, 37 cycles after start is sampled.
// Backpressure: start is ignored while busy; flush aborts at once and drops a coincident start.
module ex_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_div_seq_if.slave      bus,
    output logic [WIDTH-1:0] add_opr0,
    output logic [WIDTH-1:0] add_opr1,
    output logic             add_minus,
    input  logic [WIDTH:0]   add_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_DIV,
        S_SGN_Q,
        S_SGN_R,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             sgn_r;
    logic [WIDTH-1:0] quo_r;      // |a| on entry; quotient bits shift in from the LSB
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] den_r;      // |b|
    logic             neg_q;
    logic             neg_r;
    logic [4:0]       cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    assign diff    = add_result[WIDTH-1:0];
    assign shifted = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    // Once the partial remainder's MSB is set, the shifted value is at least 2^32 and so exceeds
    // any divisor. The adder's borrow cannot show this, so the MSB forces the subtraction.
    assign accept  = rem_r[WIDTH-1] | ~add_result[WIDTH];

    // Adder operands: negate (0 - x) for the abs and sign steps, trial subtract while dividing.
    always_comb begin
        add_opr0  = '0;
        add_opr1  = '0;
        add_minus = 1'b0;
        case (state)
            S_ABS_A: begin
                add_opr1  = dividend_r;
                add_minus = 1'b1;
            end
            S_ABS_B: begin
                add_opr1  = divisor_r;
                add_minus = 1'b1;
            end
            S_DIV: begin
                add_opr0  = shifted;
                add_opr1  = den_r;
                add_minus = 1'b1;
            end
            S_SGN_Q: begin
                add_opr1  = quo_r;
                add_minus = 1'b1;
            end
            S_SGN_R: begin
                add_opr1  = rem_r;
                add_minus = 1'b1;
            end
            default: begin
                add_opr0  = '0;
                add_opr1  = '0;
                add_minus = 1'b0;
            end
        endcase
    end

    // Control FSM and datapath registers; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dividend_r  <= '0;
            divisor_r   <= '0;
            sgn_r       <= 1'b0;
            quo_r       <= '0;
            rem_r       <= '0;
            den_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (bus.flush) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dividend_r <= bus.dividend;
                        divisor_r  <= bus.divisor;
                        sgn_r      <= bus.is_signed;
                        busy_r     <= 1'b1;
                        state      <= S_ABS_A;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ABS_A: begin
                    quo_r <= (sgn_r & dividend_r[WIDTH-1]) ? diff : dividend_r;
                    rem_r <= '0;
                    state <= S_ABS_B;
                end
                S_ABS_B: begin
                    den_r <= (sgn_r & divisor_r[WIDTH-1]) ? diff : divisor_r;
                    // A zero divisor must yield all-ones, so the quotient is never negated then.
                    neg_q <= sgn_r & (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]) & (divisor_r != '0);
                    neg_r <= sgn_r & dividend_r[WIDTH-1];
                    cnt   <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem_r <= accept ? diff : shifted;
                    quo_r <= {quo_r[WIDTH-2:0], accept};
                    cnt   <= cnt + 5'd1;
                    if (&cnt) begin
                        state <= S_SGN_Q;
                    end
                end
                S_SGN_Q: begin
                    quotient_r <= neg_q ? diff : quo_r;
                    state      <= S_SGN_R;
                end
                S_SGN_R: begin
                    remainder_r <= neg_r ? diff : rem_r;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state       <= S_DONE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq with a behavioural adder and a result scoreboard.
// Latency: checks the 36-cycle busy window and the done pulse 37 cycles after start.
// Backpressure: checks that start is ignored while busy, flush aborts, and reset clears.
module tb_ex_div_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] add_opr0;
    logic [31:0] add_opr1;
    logic        add_minus;
    logic [32:0] add_result;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_exp[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    ex_div_seq_if dif ();

    ex_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (dif.slave),
        .add_opr0   (add_opr0),
        .add_opr1   (add_opr1),
        .add_minus  (add_minus),
        .add_result (add_result)
    );

    // Combinational ex-stage adder model.
    assign add_result = add_minus ? ({1'b0, add_opr0} - {1'b0, add_opr1})
                                  : ({1'b0, add_opr0} + {1'b0, add_opr1});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results from plain arithmetic, plus the architectural corner cases.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Issue one request and wait for done. An optional stray start is pulsed at cycle inj.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inj,
                          output logic [31:0] gq, output logic [31:0] gr,
                          output logic [31:0] eq, output logic [31:0] er,
                          output int lat, output int bcnt, output bit ok);
        logic [63:0] e;
        q_exp.push_back(ref_div(a, b, s));
        @(negedge clk);
        dif.start     = 1'b1;
        dif.dividend  = a;
        dif.divisor   = b;
        dif.is_signed = s;
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
        lat  = 0;
        bcnt = 0;
        ok   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (dif.done) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
            if (dif.busy) bcnt++;
            dif.start = (k == inj);
            @(negedge clk);
        end
        dif.start = 1'b0;
        e  = q_exp.pop_front();
        eq = e[63:32];
        er = e[31:0];
        gq = dif.quotient;
        gr = dif.remainder;
        if (ok) begin
            last_q = eq;
            last_r = er;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        dif.start     = 1'b0;
        dif.flush     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        last_q        = '0;
        last_r        = '0;
        repeat (3) @(negedge clk);
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", dif.busy); end
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", dif.done); end
        checks++; if (dif.quotient !== 32'd0) begin errors++; $display("FAIL rst_quot got %h want 0", dif.quotient); end
        checks++; if (dif.remainder !== 32'd0) begin errors++; $display("FAIL rst_rem got %h want 0", dif.remainder); end
        checks++; if ({add_opr0, add_opr1, add_minus} !== 65'd0) begin errors++; $display("FAIL rst_adder got %h/%h/%b want 0", add_opr0, add_opr1, add_minus); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [31:0] gq, gr, eq, er;
        int lat, bcnt, extra;
        bit ok;
        run_op(32'd100, 32'd7, 1'b0, 10, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok) begin errors++; $display("FAIL u_timeout got no done want done"); end
        checks++; if (lat !== 36) begin errors++; $display("FAIL u_latency got %0d want 36", lat); end
        checks++; if (bcnt !== 36) begin errors++; $display("FAIL u_busy_cycles got %0d want 36", bcnt); end
        checks++; if (gq !== eq || gr !== er) begin errors++; $display("FAIL u_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'd14 || gr !== 32'd2) begin errors++; $display("FAIL u_100_7 got %0d/%0d want 14/2", gq, gr); end
        @(negedge clk);
        checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL u_done_width got %b want 0", dif.done); end
        checks++; if (dif.quotient !== 32'd14) begin errors++; $display("FAIL u_hold got %h want 0000000e", dif.quotient); end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            if (dif.done) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL u_stray_start got %0d dones want 0", extra); end
    endtask

    task automatic test_signed();
        logic [31:0] gq, gr, eq, er;
        int lat, bcnt;
        bit ok;
        run_op(-32'sd100, 32'd7, 1'b1, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== eq || gr !== er) begin errors++; $display("FAIL s_neg_a_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'hFFFF_FFF2) begin errors++; $display("FAIL s_neg_a_q got %h want fffffff2", gq); end
        checks++; if (gr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL s_neg_a_r got %h want fffffffe", gr); end
        run_op(32'd100, -32'sd7, 1'b1, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== eq || gr !== er) begin errors++; $display("FAIL s_neg_b_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'hFFFF_FFF2 || gr !== 32'd2) begin errors++; $display("FAIL s_neg_b got %h/%h want fffffff2/00000002", gq, gr); end
    endtask

    task automatic test_div_zero();
        logic [31:0] gq, gr, eq, er;
        int lat, bcnt;
        bit ok;
        run_op(32'h1234_5678, 32'd0, 1'b0, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== eq || gr !== er) begin errors++; $display("FAIL z_u_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'hFFFF_FFFF || gr !== 32'h1234_5678) begin errors++; $display("FAIL z_u got %h/%h want ffffffff/12345678", gq, gr); end
        run_op(-32'sd5, 32'd0, 1'b1, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== eq || gr !== er) begin errors++; $display("FAIL z_s_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'hFFFF_FFFF || gr !== 32'hFFFF_FFFB) begin errors++; $display("FAIL z_s got %h/%h want ffffffff/fffffffb", gq, gr); end
    endtask

    task automatic test_overflow();
        logic [31:0] gq, gr, eq, er;
        int lat, bcnt;
        bit ok;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== 32'h8000_0000 || gr !== 32'd0) begin errors++; $display("FAIL ovf_s got %h/%h want 80000000/00000000", gq, gr); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== eq || gr !== er) begin errors++; $display("FAIL ovf_u_sb got %h/%h want %h/%h", gq, gr, eq, er); end
        checks++; if (gq !== 32'd0 || gr !== 32'h8000_0000) begin errors++; $display("FAIL ovf_u got %h/%h want 00000000/80000000", gq, gr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] gq, gr, eq, er;
        logic [63:0] e;
        int lat, bcnt, gap;
        bit ok;
        run_op(32'd50, 32'd5, 1'b0, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || gq !== 32'd10 || gr !== 32'd0) begin errors++; $display("FAIL b2b_first got %h/%h want 0000000a/00000000", gq, gr); end
        // Sitting in the DONE cycle: issue the next request now.
        q_exp.push_back(ref_div(32'hFFFF_FFFF, 32'h10, 1'b0));
        dif.start     = 1'b1;
        dif.dividend  = 32'hFFFF_FFFF;
        dif.divisor   = 32'h10;
        dif.is_signed = 1'b0;
        @(negedge clk);
        dif.start = 1'b0;
        gap = 1;
        while (gap < 60 && !dif.done) begin
            gap++;
            @(negedge clk);
        end
        checks++; if (gap !== 37) begin errors++; $display("FAIL b2b_gap got %0d want 37", gap); end
        e = q_exp.pop_front();
        checks++; if (dif.quotient !== e[63:32] || dif.remainder !== e[31:0]) begin errors++; $display("FAIL b2b_sb got %h/%h want %h", dif.quotient, dif.remainder, e); end
        checks++; if (dif.quotient !== 32'h0FFF_FFFF || dif.remainder !== 32'hF) begin errors++; $display("FAIL b2b_second got %h/%h want 0fffffff/0000000f", dif.quotient, dif.remainder); end
        last_q = e[63:32];
        last_r = e[31:0];
    endtask

    task automatic test_flush();
        int extra;
        q_exp.push_back(ref_div(32'd999, 32'd4, 1'b0));
        @(negedge clk);
        dif.start     = 1'b1;
        dif.dividend  = 32'd999;
        dif.divisor   = 32'd4;
        dif.is_signed = 1'b0;
        @(negedge clk);
        dif.start = 1'b0;
        // First busy cycle negates the dividend on the adder.
        checks++; if (add_opr0 !== 32'd0 || add_opr1 !== 32'd999 || add_minus !== 1'b1) begin errors++; $display("FAIL f_abs_a_adder got %h/%h/%b want 00000000/000003e7/1", add_opr0, add_opr1, add_minus); end
        repeat (12) @(negedge clk);
        checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL f_busy_before got %b want 1", dif.busy); end
        dif.flush = 1'b1;
        @(negedge clk);
        dif.flush = 1'b0;
        void'(q_exp.pop_back());
        checks++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin errors++; $display("FAIL f_idle got busy=%b done=%b want 0/0", dif.busy, dif.done); end
        checks++; if (dif.quotient !== last_q || dif.remainder !== last_r) begin errors++; $display("FAIL f_retain got %h/%h want %h/%h", dif.quotient, dif.remainder, last_q, last_r); end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            if (dif.done || dif.busy) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL f_quiet got %0d active cycles want 0", extra); end
    endtask

    task automatic test_flush_start();
        int act;
        @(negedge clk);
        dif.start     = 1'b1;
        dif.flush     = 1'b1;
        dif.dividend  = 32'd77;
        dif.divisor   = 32'd7;
        @(negedge clk);
        dif.start = 1'b0;
        dif.flush = 1'b0;
        act = 0;
        for (int k = 0; k < 40; k++) begin
            if (dif.busy || dif.done) act++;
            @(negedge clk);
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL fs_dropped got %0d active cycles want 0", act); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] gq, gr, eq, er;
        int lat, bcnt;
        bit ok;
        @(negedge clk);
        dif.start     = 1'b1;
        dif.dividend  = 32'd12345;
        dif.divisor   = 32'd67;
        dif.is_signed = 1'b0;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin errors++; $display("FAIL rm_status got busy=%b done=%b want 0/0", dif.busy, dif.done); end
        checks++; if (dif.quotient !== 32'd0 || dif.remainder !== 32'd0) begin errors++; $display("FAIL rm_results got %h/%h want 0/0", dif.quotient, dif.remainder); end
        checks++; if ({add_opr0, add_opr1, add_minus} !== 65'd0) begin errors++; $display("FAIL rm_adder got %h/%h/%b want 0", add_opr0, add_opr1, add_minus); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd1000, 32'd33, 1'b0, -1, gq, gr, eq, er, lat, bcnt, ok);
        checks++; if (!ok || lat !== 36) begin errors++; $display("FAIL rm_after_latency got %0d want 36", lat); end
        checks++; if (gq !== 32'd30 || gr !== 32'd10) begin errors++; $display("FAIL rm_after got %0d/%0d want 30/10", gq, gr); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_flush_start();
        test_reset_mid();
        checks++; if (q_exp.size() !== 0) begin errors++; $display("FAIL sb_empty got %0d left want 0", q_exp.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
